// File: rtl/svm_pkg.sv
// svm_pkg: shared fixed-point defaults, controller state encoding and a
// saturating adder used by the optional bias stage (SVM_CTRL_BIAS_EN).
package svm_pkg;

    localparam int FEA_I_DEF = 4;
    localparam int FEA_F_DEF = 8;
    localparam int FEA_W_DEF = FEA_I_DEF + FEA_F_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Signed add of two sign-extended operands, clamped to a w-bit signed range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/svm_ctrl_out.sv
// svm_ctrl_out: captures the drained chain sum into the result register and
// holds it until the consumer takes it. With SVM_CTRL_BIAS_EN defined the
// bias is added with saturation; otherwise the chain sum passes straight through.
module svm_ctrl_out
    import svm_pkg::*;
#(
    parameter int FEA_W = FEA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [FEA_W-1:0] chain_sum,
    input  logic [FEA_W-1:0] bias,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [FEA_W-1:0] res_score,
    output logic             res_class
);

    logic [FEA_W-1:0] score_d;

`ifdef SVM_CTRL_BIAS_EN
    // Wide signed add then clamp, so overflow never wraps the sign.
    always_comb begin
        score_d = FEA_W'(sat_add(32'(signed'(chain_sum)), 32'(signed'(bias)), FEA_W));
    end
`else
    logic bias_unused;
    assign bias_unused = ^bias;

    // Without bias the score is the raw chain sum.
    always_comb begin
        score_d = chain_sum;
    end
`endif

    // Result register: load on capture, hold until valid&ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_score <= '0;
            res_class <= 1'b0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_score <= score_d;
            res_class <= ~score_d[FEA_W-1];
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/svm_ctrl.sv
// svm_ctrl: sequencer for a daisy-chained row of svm_pe elements. Accepts one
// window of feature beats, addresses the shared coefficient ROMs, drains the
// chain and hands the score to svm_ctrl_out. Optional bias: SVM_CTRL_BIAS_EN.
module svm_ctrl
    import svm_pkg::*;
#(
    parameter int FEA_I       = FEA_I_DEF,
    parameter int FEA_F       = FEA_F_DEF,
    parameter int NUM_PE      = 8,
    parameter int FEAT_PER_PE = 36,
    parameter int ADDR_W      = 6,
    localparam int FEA_W      = FEA_I + FEA_F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fea_valid,
    output logic                    fea_ready,
    input  logic [NUM_PE*FEA_W-1:0] fea_data,
    output logic [ADDR_W-1:0]       coef_addr,
    output logic [NUM_PE*FEA_W-1:0] pe_fea,
    output logic                    pe_init,
    output logic                    pe_accumulate,
    input  logic [FEA_W-1:0]        chain_sum,
    input  logic [FEA_W-1:0]        bias,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FEA_W-1:0]        res_score,
    output logic                    res_class,
    output logic                    busy
);

    localparam int DCW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fea_cnt_q, fea_cnt_d;
    logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
    logic              cap_q;
    logic              hs;
    logic              last_beat;

    assign fea_ready     = (state_q == IDLE) || (state_q == MAC);
    assign hs            = fea_valid && fea_ready;
    assign last_beat     = (fea_cnt_q == ADDR_W'(FEAT_PER_PE - 1));
    assign coef_addr     = fea_cnt_q;
    assign pe_accumulate = (state_q == DRAIN);
    assign busy          = (state_q != IDLE);

    // State, counters and the PE-facing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fea_cnt_q   <= '0;
            drain_cnt_q <= '0;
            cap_q       <= 1'b0;
            pe_fea      <= '0;
            pe_init     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fea_cnt_q   <= fea_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            // Capture one cycle after the last accumulate so chain_sum has settled.
            cap_q       <= (state_q == DRAIN) && (drain_cnt_q == '0);
            // A zero feature freezes the PE accumulators in gap cycles.
            pe_fea      <= hs ? fea_data : '0;
            pe_init     <= hs && (fea_cnt_q == '0);
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        fea_cnt_d   = fea_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE, MAC: begin
                if (hs) begin
                    if (last_beat) begin
                        fea_cnt_d = '0;
                        state_d   = FLUSH;
                    end else begin
                        fea_cnt_d = fea_cnt_q + 1'b1;
                        state_d   = MAC;
                    end
                end
            end
            FLUSH: begin
                drain_cnt_d = DCW'(NUM_PE - 1);
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = OUT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            OUT: begin
                if (res_valid && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    svm_ctrl_out #(
        .FEA_W(FEA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .cap       (cap_q),
        .chain_sum (chain_sum),
        .bias      (bias),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_score (res_score),
        .res_class (res_class)
    );

endmodule

// File: tb/tb_svm_ctrl.sv
// tb_svm_ctrl: drives svm_ctrl (2 PEs, 3 features/PE) with a behavioural PE
// chain and coefficient ROM; expected results go to a scoreboard queue.
module tb_svm_ctrl;

    localparam int NPE = 2;
    localparam int FPP = 3;
    localparam int AW  = 6;
    localparam int W   = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             fea_valid;
    logic             fea_ready;
    logic [NPE*W-1:0] fea_data;
    logic [AW-1:0]    coef_addr;
    logic [NPE*W-1:0] pe_fea;
    logic             pe_init;
    logic             pe_accumulate;
    logic [W-1:0]     chain_sum;
    logic [W-1:0]     bias;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_score;
    logic             res_class;
    logic             busy;

    int total = 0;
    int bad   = 0;
    logic [W:0] sb[$];  // {class, score}

    // Behavioural PE chain and ROM.
    logic signed [W-1:0] coef_q;
    logic signed [W-1:0] acc[NPE];
    logic signed [W-1:0] od[NPE];
    logic                ovr_en;
    logic [W-1:0]        ovr;

    always #5 clk = ~clk;

    svm_ctrl #(
        .NUM_PE      (NPE),
        .FEAT_PER_PE (FPP),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fea_valid     (fea_valid),
        .fea_ready     (fea_ready),
        .fea_data      (fea_data),
        .coef_addr     (coef_addr),
        .pe_fea        (pe_fea),
        .pe_init       (pe_init),
        .pe_accumulate (pe_accumulate),
        .chain_sum     (chain_sum),
        .bias          (bias),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_score     (res_score),
        .res_class     (res_class),
        .busy          (busy)
    );

    function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        return p[W+7:8];
    endfunction

    always @(posedge clk) begin
        coef_q <= (coef_addr < AW'(FPP)) ? 12'sh080 : 12'sh000;
        for (int k = 0; k < NPE; k++) begin
            if (pe_init) acc[k] <= mulq(pe_fea[k*W +: W], coef_q);
            else         acc[k] <= acc[k] + mulq(pe_fea[k*W +: W], coef_q);
        end
        if (pe_accumulate) begin
            od[0] <= acc[0];
            for (int k = 1; k < NPE; k++) od[k] <= od[k-1] + acc[k];
        end
    end

    assign chain_sum = ovr_en ? ovr : od[NPE-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: pop and compare every accepted result.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("res_score", 32'(res_score), 32'(e[W-1:0]));
                chk("res_class", 32'(res_class), 32'(e[W]));
            end
        end
    end

    task automatic beat(input logic [NPE*W-1:0] d, input int b);
        bit ok;
        ok        = 1'b0;
        fea_valid = 1'b1;
        fea_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fea_ready) begin
                chk("coef_addr", 32'(coef_addr), 32'(b));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        fea_valid = 1'b0;
        if (!ok) timeout("beat");
        else begin
            chk("pe_fea", 32'(pe_fea), 32'(d));
            chk("pe_init", 32'(pe_init), 32'(b == 0));
        end
    endtask

    task automatic send_window(input logic [W-1:0] f0, input logic [W-1:0] f1, input int gap);
        for (int b = 0; b < FPP; b++) begin
            beat({f1, f0}, b);
            if (b < FPP - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    chk("gap_pe_fea", 32'(pe_fea), 32'(0));
                end
            end
        end
    endtask

    task automatic drain_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) timeout("drain_sb");
    endtask

    task automatic push(input logic [W-1:0] s, input logic c);
        sb.push_back({c, s});
    endtask

    initial begin
        int c;
        int nacc;
        rst       = 1'b1;
        fea_valid = 1'b0;
        fea_data  = '0;
        res_ready = 1'b0;
        bias      = '0;
        ovr_en    = 1'b0;
        ovr       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_score", 32'(res_score), 0);
        chk("rst_res_class", 32'(res_class), 0);
        chk("rst_pe_fea", 32'(pe_fea), 0);
        chk("rst_coef_addr", 32'(coef_addr), 0);
        rst = 1'b0;

        // 1+2: 1.0 * 0.5 over 3 beats, 2 PEs -> 3.0; latency and drain length.
        push(12'h300, 1'b1);
        send_window(12'h100, 12'h100, 0);
        c    = 0;
        nacc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (pe_accumulate) nacc++;
            if (res_valid) begin
                c = i;
                break;
            end
        end
        chk("latency", 32'(c), 4);
        chk("accumulate_cycles", 32'(nacc), 2);
        res_ready = 1'b1;
        drain_sb();
        chk("fea_ready_after_res", 32'(fea_ready), 1);

`ifdef SVM_CTRL_BIAS_EN
        bias = 12'hC00;
        push(12'hF00, 1'b0);
`else
        bias = 12'hC00;
        push(12'h300, 1'b1);
`endif
        send_window(12'h100, 12'h100, 0);
        drain_sb();
        bias = '0;

        // 4a: hold result while consumer stalls; next window's beat waits.
        res_ready = 1'b0;
        push(12'h180, 1'b1);
        send_window(12'hF00, 12'h200, 0);
        c = 0;
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk);
            #1;
            c = i;
        end
        if (!res_valid) timeout("res_valid_wait");
        fea_valid = 1'b1;
        fea_data  = {12'h100, 12'h100};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_score", 32'(res_score), 32'h180);
            chk("hold_fea_ready", 32'(fea_ready), 0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;

        // 4b: feature gaps give the same 3.0 result.
        push(12'h300, 1'b1);
        send_window(12'h100, 12'h100, 2);
        drain_sb();

        // 5: reset mid-window, then a clean window.
        beat({12'h100, 12'h100}, 0);
        beat({12'h100, 12'h100}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pe_fea", 32'(pe_fea), 0);
        chk("midrst_pe_init", 32'(pe_init), 0);
        chk("midrst_pe_acc", 32'(pe_accumulate), 0);
        chk("midrst_coef_addr", 32'(coef_addr), 0);
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_res_score", 32'(res_score), 0);
        rst = 1'b0;
        push(12'h300, 1'b1);
        send_window(12'h100, 12'h100, 0);
        drain_sb();

        // 3: saturation with an overridden chain sum.
        ovr_en = 1'b1;
        ovr    = 12'h7F0;
        bias   = 12'h100;
`ifdef SVM_CTRL_BIAS_EN
        push(12'h7FF, 1'b1);
`else
        push(12'h7F0, 1'b1);
`endif
        send_window(12'h100, 12'h100, 0);
        drain_sb();
        ovr  = 12'h810;
        bias = 12'hF00;
`ifdef SVM_CTRL_BIAS_EN
        push(12'h800, 1'b0);
`else
        push(12'h810, 1'b0);
`endif
        send_window(12'h100, 12'h100, 0);
        drain_sb();
        ovr_en = 1'b0;
        bias   = '0;

        // 6: two windows back to back, consumer always ready.
        push(12'h300, 1'b1);
        push(12'hD00, 1'b0);
        send_window(12'h100, 12'h100, 0);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                c = 1;
                break;
            end
        end
        if (c == 0) timeout("win_a_result");
        @(posedge clk);
        #1;
        chk("reaccept_fea_ready", 32'(fea_ready), 1);
        chk("reaccept_busy", 32'(busy), 0);
        send_window(12'hF00, 12'hF00, 0);
        drain_sb();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
